// File: rtl/cdr_decision_mv.sv
// Chip-decision stage of the CDR: tracks the sample position within each chip,
// decides each chip from its centre sample or a majority vote, and re-times frame sync.
module cdr_decision_mv #(
  parameter int unsigned NB_P_W       = 6,
  parameter int unsigned PHASE_W      = 2,
  parameter int unsigned STROBE_PHASE = 3,
  parameter int unsigned VOTE_MAX     = 7,
  parameter bit          INVERT       = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_dir,
  input  logic [PHASE_W-1:0] i_cnt_d,
  input  logic [NB_P_W-1:0] i_nb_P,
  input  logic [2:0]        i_vote,
  input  logic              i_mode,
  input  logic              i_flag,
  output logic              o_data,
  output logic              o_valid,
  output logic              o_conf,
  output logic              o_flag,
  output logic              o_cfg_err
);

  localparam int unsigned W = NB_P_W + 1;

  logic              strobe;
  logic              cfg_err_d, cfg_err_q;
  logic [NB_P_W-1:0] cnt_d, cnt_q;
  logic [2:0]        ones_d, ones_q;
  logic              pending_d, pending_q;
  logic              data_d, data_q;
  logic              valid_d, valid_q;
  logic              conf_d, conf_q;
  logic              flag_d, flag_q;
  logic [2:0]        vote_m1;
  logic [2:0]        acc;
  logic [W-1:0]      nbp_m1, c, h, lo, hi, cnt_x, veff;
  logic              in_win, at_hi;

  always_comb begin
    strobe    = (i_cnt_d == PHASE_W'(STROBE_PHASE));
    cfg_err_d = (i_nb_P < NB_P_W'(2)) | ~i_vote[0] | (32'(i_vote) > VOTE_MAX)
              | (i_mode & (NB_P_W'(i_vote) > i_nb_P));

    // Window bounds are formed in NB_P_W+1 bits so out-of-range configs wrap predictably.
    vote_m1 = i_vote - 3'd1;
    nbp_m1  = W'(i_nb_P) - W'(1);
    c       = nbp_m1 >> 1;
    h       = i_mode ? W'(vote_m1[2:1]) : '0;
    lo      = c - h;
    hi      = c + h;
    veff    = (h << 1) + W'(1);
    cnt_x   = W'(cnt_q);
    in_win  = (cnt_x >= lo) && (cnt_x <= hi);
    at_hi   = (cnt_x == hi);

    if (cnt_x == lo) begin
      acc = {2'b00, i_dir};
    end else if (32'(ones_q) >= VOTE_MAX) begin
      acc = ones_q;
    end else begin
      acc = ones_q + {2'b00, i_dir};
    end

    cnt_d     = cnt_q;
    ones_d    = ones_q;
    pending_d = pending_q | i_flag;
    data_d    = data_q;
    valid_d   = 1'b0;
    conf_d    = conf_q;
    flag_d    = 1'b0;

    if (cfg_err_q) begin
      cnt_d  = '0;
      ones_d = '0;
    end else if (strobe) begin
      cnt_d = (cnt_x >= nbp_m1) ? '0 : cnt_q + NB_P_W'(1);
      if (in_win) begin
        ones_d = acc;
      end
      // A flag arriving on the decision strobe itself attaches to this decision.
      if (at_hi) begin
        valid_d   = 1'b1;
        data_d    = (W'(acc) > h) ^ INVERT;
        conf_d    = (acc == 3'd0) | (W'(acc) == veff);
        flag_d    = pending_q | i_flag;
        pending_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cfg_err_q <= 1'b0;
      cnt_q     <= '0;
      ones_q    <= '0;
      pending_q <= 1'b0;
      data_q    <= 1'b0;
      valid_q   <= 1'b0;
      conf_q    <= 1'b0;
      flag_q    <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_d;
      cnt_q     <= cnt_d;
      ones_q    <= ones_d;
      pending_q <= pending_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      conf_q    <= conf_d;
      flag_q    <= flag_d;
    end
  end

  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_conf    = conf_q;
  assign o_flag    = flag_q;
  assign o_cfg_err = cfg_err_q;

endmodule

// File: tb/tb_cdr_decision_mv.sv
// Scoreboard bench for cdr_decision_mv: a sample-list reference model queues expected
// decisions at each decision strobe; a negedge monitor pops and compares on o_valid.
module tb_cdr_decision_mv;

  logic       clk = 1'b0;
  logic       rst;
  logic       dir;
  logic [1:0] cnt_d;
  logic [5:0] nbp;
  logic [2:0] vote;
  logic       mode;
  logic       flag;
  logic       o_data, o_valid, o_conf, o_flag, o_cfg_err;

  int checks   = 0;
  int failures = 0;

  typedef struct { bit data; bit conf; bit flag; } exp_t;
  exp_t sb[$];

  // reference model state
  int m_pos;
  bit m_samp[$];
  bit m_pend;
  bit m_cfg;

  // stimulus controls
  int strobe_kind; // 0: every 4th clk, 1: random, 2: every clk
  int dir_kind;    // 0/1: fixed value, 2: random
  int flag_pct;

  bit exp_data, exp_conf;

  cdr_decision_mv #(
    .NB_P_W(6), .PHASE_W(2), .STROBE_PHASE(3), .VOTE_MAX(7), .INVERT(1'b1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_dir(dir), .i_cnt_d(cnt_d), .i_nb_P(nbp),
    .i_vote(vote), .i_mode(mode), .i_flag(flag),
    .o_data(o_data), .o_valid(o_valid), .o_conf(o_conf), .o_flag(o_flag),
    .o_cfg_err(o_cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b expected=%0b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: works from the rule text with plain integers and a sample list.
  always @(posedge clk or posedge rst) begin : model
    int c, h, lo, hi, tot, nm1;
    bit cfg_now;
    exp_t e;
    if (rst) begin
      m_pos = 0;
      m_samp.delete();
      m_pend = 0;
      m_cfg = 0;
    end else begin
      cfg_now = (nbp < 2) || (vote % 2 == 0) || (vote > 7) || (mode && (vote > nbp));
      if (m_cfg) begin
        m_pos = 0;
        m_samp.delete();
        m_pend = m_pend | flag;
      end else if (cnt_d == 2'd3) begin
        nm1 = (int'(nbp) - 1) & 127;
        c   = nm1 >> 1;
        h   = mode ? ((((int'(vote) - 1) & 7)) >> 1) : 0;
        lo  = (c - h) & 127;
        hi  = c + h;
        if (m_pos == lo) tot = dir;
        else begin
          tot = dir;
          foreach (m_samp[i]) tot += m_samp[i];
          if (tot > 7) tot = 7;
        end
        if (m_pos == lo) begin
          m_samp.delete();
          m_samp.push_back(dir);
        end else if (m_pos > lo && m_pos <= hi) begin
          m_samp.push_back(dir);
        end
        if (m_pos == hi) begin
          e.data = !(tot > h);
          e.conf = (tot == 0) || (tot == 2 * h + 1);
          e.flag = m_pend | flag;
          m_pend = 0;
          sb.push_back(e);
        end else begin
          m_pend = m_pend | flag;
        end
        m_pos = (m_pos >= nm1) ? 0 : (m_pos + 1) % 64;
      end else begin
        m_pend = m_pend | flag;
      end
      m_cfg = cfg_now;
    end
  end

  always @(negedge clk or posedge rst) begin : monitor
    exp_t e;
    if (rst) begin
      exp_data = 0;
      exp_conf = 0;
      sb.delete();
    end else begin
      chk("cfg_err", o_cfg_err, m_cfg);
      if (o_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", o_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("flag", o_flag, e.flag);
          exp_data = e.data;
          exp_conf = e.conf;
        end
      end else begin
        chk("flag_idle", o_flag, 1'b0);
      end
      chk("data", o_data, exp_data);
      chk("conf", o_conf, exp_conf);
    end
  end

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      case (strobe_kind)
        0:       cnt_d = cnt_d + 2'd1;
        1:       cnt_d = 2'($urandom_range(0, 3));
        default: cnt_d = 2'd3;
      endcase
      dir  = (dir_kind == 2) ? 1'($urandom_range(0, 1)) : 1'(dir_kind);
      flag = ($urandom_range(0, 99) < flag_pct);
    end
  endtask

  initial begin
    rst = 1'b1; dir = 1'b0; cnt_d = 2'd0; nbp = 6'd8; vote = 3'd1; mode = 1'b0; flag = 1'b0;
    strobe_kind = 0; dir_kind = 1; flag_pct = 0;
    repeat (3) @(negedge clk);
    chk("rst_data", o_data, 1'b0);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_conf", o_conf, 1'b0);
    chk("rst_flag", o_flag, 1'b0);
    chk("rst_cfg", o_cfg_err, 1'b0);
    rst = 1'b0;

    // centre sample only, constant ones
    step(200);

    // 5-sample majority, random data, random strobes and flags
    mode = 1'b1; vote = 3'd5; dir_kind = 2; strobe_kind = 1; flag_pct = 8;
    step(600);

    // window longer than chip: no decisions until V is reduced
    nbp = 6'd4; strobe_kind = 0;
    step(400);
    vote = 3'd3;
    step(300);

    // shrink chip length mid-chip
    nbp = 6'd16; vote = 3'd7; strobe_kind = 2;
    begin : shrink
      bit hit = 0;
      for (int k = 0; k < 200 && !hit; k++) begin
        step(1);
        if (m_pos == 12 && !m_cfg) hit = 1;
      end
      chk("wait_pos12", hit, 1'b1);
    end
    nbp = 6'd8;
    step(300);

    // random configurations, occasionally invalid
    strobe_kind = 1;
    for (int r = 0; r < 20; r++) begin
      nbp  = 6'($urandom_range(2, 20));
      vote = 3'(2 * $urandom_range(0, 3) + 1);
      mode = 1'($urandom_range(0, 1));
      if (r % 5 == 4) nbp = 6'($urandom_range(0, 3));
      strobe_kind = $urandom_range(0, 2);
      step(150);
    end

    // asynchronous reset in the middle of a window with a flag pending
    nbp = 6'd8; vote = 3'd5; mode = 1'b1; strobe_kind = 2; flag_pct = 30;
    step(3);
    begin : midwin
      bit hit = 0;
      for (int k = 0; k < 300 && !hit; k++) begin
        step(1);
        if (m_pos == 4 && m_pend && !m_cfg) hit = 1;
      end
      chk("wait_pos4", hit, 1'b1);
    end
    flag_pct = 0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_data", o_data, 1'b0);
    chk("arst_valid", o_valid, 1'b0);
    chk("arst_conf", o_conf, 1'b0);
    chk("arst_flag", o_flag, 1'b0);
    chk("arst_cfg", o_cfg_err, 1'b0);
    step(2);
    rst = 1'b0;
    flag_pct = 5; strobe_kind = 1;
    step(300);

    flag_pct = 0; strobe_kind = 0;
    step(20);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain actual=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
